// File: rtl/stack_mem.sv
// LIFO for return addresses and stack data. It has a registered pop output,
// a pointer that saturates at empty and full, and sticky overflow/underflow flags.
module stack_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear_err,
  input  logic [DW-1:0] write_data_stack,
  output logic [DW-1:0] read_data_stack,
  output logic [AW:0]   sp,
  output logic          stack_empty,
  output logic          stack_full,
  output logic          stack_overflow,
  output logic          stack_underflow
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;
  logic          do_swap;
  logic          do_push;
  logic          do_pop;
  logic          ovf_evt;
  logic          unf_evt;
  logic          mem_we;

  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == (AW+1)'(DEPTH));

  // When full, sp[AW-1:0] is 0, and the subtraction wraps to DEPTH-1, which is the top entry.
  assign top_idx = sp[AW-1:0] - 1'b1;

  // Push and pop together on an empty stack act as a plain push.
  assign do_swap = push & pop & ~stack_empty;
  assign do_push = push & ~do_swap & ~stack_full;
  assign do_pop  = pop & ~push & ~stack_empty;
  assign ovf_evt = push & ~pop & stack_full;
  assign unf_evt = pop & ~push & stack_empty;

  assign wr_idx = do_swap ? top_idx : sp[AW-1:0];
  assign mem_we = ~reset & (do_swap | do_push);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= write_data_stack;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp              <= '0;
      read_data_stack <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      if (do_push) begin
        sp <= sp + 1'b1;
      end else if (do_pop) begin
        sp <= sp - 1'b1;
      end

      if (do_swap | do_pop) begin
        read_data_stack <= mem[top_idx];
      end

      // A new error in the same cycle as clear_err keeps the flag set.
      if (ovf_evt) begin
        stack_overflow <= 1'b1;
      end else if (clear_err) begin
        stack_overflow <= 1'b0;
      end

      if (unf_evt) begin
        stack_underflow <= 1'b1;
      end else if (clear_err) begin
        stack_underflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/stack_mem.md
# stack_mem

Hardware LIFO holding 11-bit entries: return addresses for call/return and general stack data for `lw`/`lwra`. It sits directly upstream of the stack/accumulator write-back mux. Its registered `read_data_stack` output feeds that mux, which forwards bits [7:0] to the register file when `MemtoReg`=0. It tracks the stack pointer and full/empty state, and latches sticky overflow/underflow errors for the control unit.

## Interface
- `DEPTH`, 16: number of entries; power of two, minimum 2.
- `AW`, 4: log2(`DEPTH`); entry address width.
- `DW`, 11: entry width. Matches the PC width and the write-back mux input.

- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `push`  in  1  push `write_data_stack` this cycle.
- `pop`  in  1  pop the top entry this cycle.
- `clear_err`  in  1  clears the sticky error flags.
- `write_data_stack`  in  `DW`  data to push (PC+1 on call, register value on store).
- `read_data_stack`  out  `DW`  registered popped value; goes to the write-back mux.
- `sp`  out  `AW`+1  current entry count, 0..`DEPTH`.
- `stack_empty`  out  1  high when `sp`==0.
- `stack_full`  out  1  high when `sp`==`DEPTH`.
- `stack_overflow`  out  1  sticky; set by a push while full.
- `stack_underflow`  out  1  sticky; set by a pop while empty.

## Operation
Storage and pointer:
- `mem[0..DEPTH-1]`, `DW` bits wide. Memory is not reset; only `sp`, `read_data_stack` and the flags are.
- `sp` points one past the top entry, so the top entry is `mem[sp-1]`.
- `stack_empty` and `stack_full` decode combinationally from `sp`.

Per-cycle action, decided on the sampled `push`/`pop` and the current `sp` (priority top-down):
- `reset`: `sp`=0, `read_data_stack`=0, both error flags 0. Overrides every other input, including mid-operation.
- `push`&`pop`, not empty (swap): `read_data_stack` <= `mem[sp-1]`; `mem[sp-1]` <= `write_data_stack`; `sp` unchanged. Legal when full.
- `push`&`pop`, empty: treated as a push only. No underflow; `read_data_stack` holds.
- `push` only, not full: `mem[sp]` <= `write_data_stack`; `sp` <= `sp`+1.
- `push` only, full: no write; `sp` holds; `stack_overflow` <= 1.
- `pop` only, not empty: `read_data_stack` <= `mem[sp-1]`; `sp` <= `sp`-1.
- `pop` only, empty: `sp` holds; `read_data_stack` holds; `stack_underflow` <= 1.
- Idle: all state holds. `read_data_stack` keeps the last popped value indefinitely.

Error flags:
- `clear_err` clears both flags.
- If an error event occurs in the same cycle as `clear_err`, the set wins.

Arithmetic and bounds:
- `sp` is `AW`+1 bits wide and never wraps.
- The full/empty guards make `sp`=`DEPTH`+1 and `sp`=-1 unreachable.

## Timing
- `push`, `pop`, `write_data_stack` and `clear_err` are sampled at rising edge N. Their effects on `sp`, the flags, `mem` and `read_data_stack` are visible after edge N.
- Pop latency is 1 cycle: `pop` at edge N means `read_data_stack` is valid from edge N through at least edge N+1. This suits a control unit that asserts `pop` in the execute cycle and `MemtoReg`=0 in the following write-back cycle.
- Push-to-pop: a push at edge N followed by a pop at edge N+1 returns the pushed data after edge N+1. No forwarding hazard, since the write completes at edge N.
- `stack_empty`, `stack_full` and `sp` reflect post-edge state in the same cycle. There is no combinational path from `push`/`pop` to any output.
- Throughput is one operation per cycle, with no stalls or handshake. The control unit must not rely on `read_data_stack` changing on an illegal pop.

## Test plan
- Reset and basic pop:
  - After `reset` (1 cycle): `sp`=0, `stack_empty`=1, `stack_full`=0, `read_data_stack`=0, flags 0.
  - Then push 11'h5A3, pop: `read_data_stack`=11'h5A3 one cycle after the pop edge, `sp` back to 0.
- LIFO order and full:
  - Push 16 values 11'h000..11'h00F: `stack_full`=1, `sp`=16.
  - Push 11'h7FF: `stack_overflow`=1, `sp`=16.
  - 16 pops then return 11'h00F..11'h000 in order, ending with `stack_empty`=1. 11'h7FF never appears.
- Underflow and clear:
  - Pop when empty: `stack_underflow`=1, `read_data_stack` unchanged, `sp`=0.
  - `clear_err` next cycle: flag 0.
  - Pop and `clear_err` together while empty: flag stays 1.
- Swap:
  - With stack {11'h100, 11'h200 (top)}, `push`&`pop` with data 11'h333: `read_data_stack`=11'h200, `sp`=2.
  - Subsequent pops return 11'h333 then 11'h100.
  - `push`&`pop` when empty with 11'h044: `sp`=1, no underflow; next pop returns 11'h044.
- Reset mid-operation:
  - After 5 pushes and a pop holding 11'h123, assert `reset` together with `push`: `sp`=0, `read_data_stack`=0, flags 0, nothing pushed.
  - A following pop sets `stack_underflow`.
